// File: rtl/cnn_quant_pkg.sv
// Shared quantization constants and rounding helper for the conv1x1 post-processing path.
// Widths here must agree with the conv engine's output stage.
package cnn_quant_pkg;

  localparam int IN_WIDTH    = 18;
  localparam int MULT_WIDTH  = 16;
  localparam int SHIFT_WIDTH = 5;
  localparam int OUT_WIDTH   = 8;
  localparam int CNT_WIDTH   = 16;
  localparam int PROD_WIDTH  = IN_WIDTH + MULT_WIDTH;
  localparam int UQ_MAX      = (1 << OUT_WIDTH) - 1;

  // Round half toward +infinity, then arithmetic shift; one guard bit keeps the add from overflowing.
  function automatic logic signed [PROD_WIDTH:0] round_shift(
    input logic signed [PROD_WIDTH-1:0] p,
    input logic        [SHIFT_WIDTH-1:0] shift
  );
    logic signed [PROD_WIDTH:0] half;
    logic signed [PROD_WIDTH:0] sum;
    half = '0;
    if (shift != '0) begin
      half[shift - 1'b1] = 1'b1;
    end
    sum = $signed({p[PROD_WIDTH-1], p}) + half;
    return sum >>> shift;
  endfunction

endpackage

// File: rtl/requant_relu_stage_if.sv
// Valid/ready stream pair around the requant stage: pre-activation in, 8-bit activation out.
// The master side is whoever feeds din and consumes dout; the stage itself is the slave.
interface requant_relu_stage_if #(
  parameter int IN_WIDTH  = cnn_quant_pkg::IN_WIDTH,
  parameter int OUT_WIDTH = cnn_quant_pkg::OUT_WIDTH
);

  logic signed [IN_WIDTH-1:0]  din;
  logic                        din_valid;
  logic                        din_ready;
  logic        [OUT_WIDTH-1:0] dout;
  logic                        dout_valid;
  logic                        dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );

endinterface

// File: rtl/requant_relu_stage_round_shift_sat.sv
// Combinational datapath of the requant stage: rounding shift (stage 2) and
// ReLU / zero-point / unsigned clamp (stage 3). The pipeline registers live in the top.
module round_shift_sat
  import cnn_quant_pkg::*;
(
  input  logic signed [PROD_WIDTH-1:0] p,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [PROD_WIDTH:0]   r,
  input  logic signed [PROD_WIDTH:0]   r_in,
  input  logic                         relu,
  input  logic        [OUT_WIDTH-1:0]  zp,
  output logic        [OUT_WIDTH-1:0]  q,
  output logic                         sat
);

  localparam int YW = PROD_WIDTH + 2;

  logic signed [PROD_WIDTH:0] r_clamped;
  logic signed [YW-1:0]       y;

  assign r = round_shift(p, shift);

  always_comb begin
    r_clamped = r_in;
    if (relu && r_in[PROD_WIDTH]) begin
      r_clamped = '0;
    end
    y   = $signed({r_clamped[PROD_WIDTH], r_clamped}) + $signed({{(YW-OUT_WIDTH){1'b0}}, zp});
    q   = y[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (y > $signed(YW'(UQ_MAX))) begin
      q   = '1;
      sat = 1'b1;
    end else if (y[YW-1]) begin
      q   = '0;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/requant_relu_stage.sv
// Three-stage requantization after the 1x1 conv engine: multiply, round-shift, ReLU/zero-point/saturate.
// Shares the conv engine's global-stall valid/ready scheme so the two chain directly.
module requant_relu_stage
  import cnn_quant_pkg::*;
#(
  parameter int IN_WIDTH    = cnn_quant_pkg::IN_WIDTH,
  parameter int MULT_WIDTH  = cnn_quant_pkg::MULT_WIDTH,
  parameter int SHIFT_WIDTH = cnn_quant_pkg::SHIFT_WIDTH,
  parameter int OUT_WIDTH   = cnn_quant_pkg::OUT_WIDTH,
  parameter int CNT_WIDTH   = cnn_quant_pkg::CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  requant_relu_stage_if.slave           bus,
  input  logic signed [MULT_WIDTH-1:0]  mult_config,
  input  logic        [SHIFT_WIDTH-1:0] shift_config,
  input  logic        [OUT_WIDTH-1:0]   zp_config,
  input  logic                          relu_config,
  input  logic                          config_en,
  output logic                          config_err,
  output logic        [CNT_WIDTH-1:0]   sat_count
);

  localparam int PW = IN_WIDTH + MULT_WIDTH;

  logic signed [MULT_WIDTH-1:0]  mult_reg;
  logic        [SHIFT_WIDTH-1:0] shift_reg;
  logic        [OUT_WIDTH-1:0]   zp_reg;
  logic                          relu_reg;

  logic signed [PW-1:0]          p1_reg;
  logic signed [PW:0]            r2_reg;
  logic        [OUT_WIDTH-1:0]   dout_reg;
  logic                          sat3_reg;
  logic                          v1_reg;
  logic                          v2_reg;
  logic                          v3_reg;
  logic        [CNT_WIDTH-1:0]   sat_cnt_reg;

  logic signed [PW-1:0]          prod_next;
  logic signed [PW:0]            r_next;
  logic        [OUT_WIDTH-1:0]   q_next;
  logic                          sat_next;
  logic                          pipe_en;
  logic                          pipe_empty;
  logic                          cfg_accept;
  logic                          out_xfer;

  assign pipe_en       = bus.dout_ready | ~v3_reg;
  assign bus.din_ready = pipe_en;
  assign out_xfer      = v3_reg & bus.dout_ready;

  // Config may only change with nothing in flight and nothing arriving, so no beat sees a mix.
  assign pipe_empty = ~v1_reg & ~v2_reg & ~v3_reg & ~bus.din_valid;
  assign cfg_accept = config_en & pipe_empty;
  assign config_err = config_en & ~pipe_empty;

  assign prod_next = $signed({{MULT_WIDTH{bus.din[IN_WIDTH-1]}}, bus.din})
                   * $signed({{IN_WIDTH{mult_reg[MULT_WIDTH-1]}}, mult_reg});

  round_shift_sat u_round_shift_sat (
    .p     (p1_reg),
    .shift (shift_reg),
    .r     (r_next),
    .r_in  (r2_reg),
    .relu  (relu_reg),
    .zp    (zp_reg),
    .q     (q_next),
    .sat   (sat_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_reg   <= '0;
      r2_reg   <= '0;
      dout_reg <= '0;
      sat3_reg <= 1'b0;
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
      v3_reg   <= 1'b0;
    end else if (pipe_en) begin
      p1_reg   <= prod_next;
      r2_reg   <= r_next;
      dout_reg <= q_next;
      sat3_reg <= sat_next;
      v1_reg   <= bus.din_valid;
      v2_reg   <= v1_reg;
      v3_reg   <= v2_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_reg  <= '0;
      shift_reg <= '0;
      zp_reg    <= '0;
      relu_reg  <= 1'b0;
    end else if (cfg_accept) begin
      mult_reg  <= mult_config;
      shift_reg <= shift_config;
      zp_reg    <= zp_config;
      relu_reg  <= relu_config;
    end
  end

  // Saturation counter sticks at all ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_reg <= '0;
    end else if (cfg_accept) begin
      sat_cnt_reg <= '0;
    end else if (out_xfer && sat3_reg && (sat_cnt_reg != '1)) begin
      sat_cnt_reg <= sat_cnt_reg + 1'b1;
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = v3_reg;
  assign sat_count      = sat_cnt_reg;

endmodule

// File: tb/tb_requant_relu_stage.sv
// Self-checking bench for requant_relu_stage: directed scenarios plus a randomized
// stream scored against an arithmetic reference model.
module tb_requant_relu_stage;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [15:0] mult_config;
  logic        [4:0]  shift_config;
  logic        [7:0]  zp_config;
  logic               relu_config;
  logic               config_en;
  logic               config_err;
  logic        [15:0] sat_count;

  requant_relu_stage_if bus ();

  requant_relu_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mult_config  (mult_config),
    .shift_config (shift_config),
    .zp_config    (zp_config),
    .relu_config  (relu_config),
    .config_en    (config_en),
    .config_err   (config_err),
    .sat_count    (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct { int q; bit sat; } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_mult, cur_shift, cur_zp, cur_relu;
  int   sat_model;
  exp_t exp_q[$];

  task automatic check_val(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: exact integer arithmetic with floor division for the rounded shift.
  function automatic exp_t ref_q(input longint d);
    longint p, r, y, dv, num;
    exp_t   e;
    p = d * longint'(cur_mult);
    if (cur_shift == 0) begin
      r = p;
    end else begin
      dv  = longint'(1) << cur_shift;
      num = p + dv / 2;
      r   = num / dv;
      if ((num % dv) != 0 && num < 0) r = r - 1;
    end
    if (cur_relu != 0 && r < 0) r = 0;
    y = r + cur_zp;
    if (y > 255) begin
      e.q = 255; e.sat = 1'b1;
    end else if (y < 0) begin
      e.q = 0; e.sat = 1'b1;
    end else begin
      e.q = int'(y); e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input int m, input int s, input int z, input int r);
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (4) tick();
    mult_config  = 16'(m);
    shift_config = 5'(s);
    zp_config    = 8'(z);
    relu_config  = r[0];
    config_en    = 1'b1;
    #1;
    check_val("cfg_err_idle", config_err, 0);
    tick();
    config_en = 1'b0;
    cur_mult  = m;
    cur_shift = s;
    cur_zp    = z;
    cur_relu  = r;
    sat_model = 0;
    check_val("cfg_sat_clear", sat_count, 0);
  endtask

  task automatic single(input string tag, input int d, input int exp_dout, input int exp_sat);
    int lat;
    bus.din        = 18'(d);
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    lat = 1;
    while (!bus.dout_valid && lat < 8) begin
      tick();
      lat++;
    end
    $display("beat %s: din=%0d dout=%0d latency=%0d", tag, d, bus.dout, lat);
    check_val({tag, "_lat"}, lat, 3);
    check_val(tag, bus.dout, exp_dout);
    tick();
    check_val({tag, "_sat"}, sat_count, exp_sat);
  endtask

  task automatic run_cycles(input int n, input bit feed);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      bus.din_valid  = feed && ($urandom_range(0, 3) != 0);
      bus.din        = ($urandom_range(0, 1) != 0) ? 18'($urandom) : 18'(int'($urandom_range(0, 1023)) - 512);
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_val("din_ready_rule", bus.din_ready, bus.dout_ready | !bus.dout_valid);
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", bus.dout_valid, 0);
        end else begin
          e = exp_q.pop_front();
          $display("rand beat: dout=%0d expected=%0d sat=%0d", bus.dout, e.q, e.sat);
          check_val("rand_dout", bus.dout, e.q);
          if (e.sat && sat_model != 65535) sat_model++;
        end
      end
      if (bus.din_valid && bus.din_ready) exp_q.push_back(ref_q(longint'(bus.din)));
      tick();
      check_val("rand_sat", sat_count, sat_model);
    end
  endtask

  initial begin
    int outs[$];
    int k, prev, m;
    bit held;

    rst_n = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.dout_ready = 1'b1;
    mult_config = '0; shift_config = '0; zp_config = '0; relu_config = 1'b0; config_en = 1'b0;
    @(negedge clk);
    check_val("rst_dout_valid", bus.dout_valid, 0);
    check_val("rst_dout", bus.dout, 0);
    check_val("rst_sat", sat_count, 0);
    check_val("rst_cfg_err", config_err, 0);
    check_val("rst_din_ready", bus.din_ready, 1);
    rst_n = 1'b1;
    tick();

    // Scaling by 0.5 with round-half-up, then ReLU / zero point / saturation.
    cfg(16384, 15, 0, 1);
    single("scale_101", 101, 51, 0);
    single("scale_100", 100, 50, 0);
    single("relu_neg", -20, 0, 0);
    cfg(16384, 15, 128, 0);
    single("zp_neg", -20, 118, 0);
    cfg(16384, 15, 0, 0);
    single("neg_sat", -20, 0, 1);
    cfg(16384, 15, 0, 0);
    single("pos_sat", 1000, 255, 1);
    single("min_sat", -131072, 0, 2);

    // Config request with a beat in stage 2 is refused and the old scale is applied.
    bus.din = 18'(100); bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    tick();
    mult_config = -7; shift_config = 3; zp_config = 9; relu_config = 1'b1; config_en = 1'b1;
    #1;
    check_val("guard_cfg_err", config_err, 1);
    tick();
    config_en = 1'b0;
    #1;
    check_val("guard_err_pulse", config_err, 0);
    check_val("guard_valid", bus.dout_valid, 1);
    check_val("guard_old_scale", bus.dout, 50);
    check_val("guard_sat_kept", sat_count, 2);
    $display("config guard: refused request, dout=%0d", bus.dout);
    cfg(16384, 15, 0, 1);

    // Backpressure: stream 2,4,6,8,10 with dout_ready low for 4 cycles mid-stream.
    k = 0; prev = 0; held = 1'b0;
    for (int c = 0; c < 40 && outs.size() < 5; c++) begin
      bus.din_valid  = (k < 5);
      bus.din        = 18'(2 * (k + 1));
      bus.dout_ready = !(c >= 3 && c < 7);
      #1;
      if (held) check_val("bp_hold", bus.dout, prev);
      if (bus.dout_valid && !bus.dout_ready) begin
        check_val("bp_din_ready", bus.din_ready, 0);
        held = 1'b1;
        prev = bus.dout;
      end else begin
        held = 1'b0;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        outs.push_back(bus.dout);
        $display("bp beat: dout=%0d", bus.dout);
      end
      if (bus.din_valid && bus.din_ready) k++;
      tick();
    end
    bus.din_valid = 1'b0;
    check_val("bp_count", outs.size(), 5);
    for (int i = 0; i < outs.size(); i++) check_val("bp_order", outs[i], i + 1);

    // Randomized streams under random configurations.
    for (int ci = 0; ci < 6; ci++) begin
      m = int'($urandom_range(0, 65535)) - 32768;
      cfg(m, (ci == 0) ? 0 : int'($urandom_range(8, 24)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      run_cycles(250, 1'b1);
      run_cycles(10, 1'b0);
      check_val("rand_drained", exp_q.size(), 0);
      exp_q.delete();
    end

    // Reset with three beats in flight.
    cfg(16384, 15, 100, 0);
    bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.din = 18'(1000 + i);
      tick();
    end
    bus.din_valid = 1'b0;
    check_val("pre_rst_valid", bus.dout_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", bus.dout_valid, 0);
    check_val("mid_rst_dout", bus.dout, 0);
    check_val("mid_rst_sat", sat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("post_rst_idle", bus.dout_valid, 0);
    end
    single("post_rst_cfg0", 1000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/requant_relu_stage.md
Name: requant_relu_stage

Overview:
- Post-processing stage directly downstream of the 1x1 convolution engine.
- Consumes its signed 18-bit multiply-plus-bias results and applies a per-tensor fixed-point rescale with round-half-up, optional ReLU, zero-point add and unsigned saturation.
- Produces 8-bit activations for the next layer's input.
- Same valid/ready stall scheme as the conv engine, so the two chain with no glue logic.

Parameters:
- IN_WIDTH, 18, signed input width; matches the conv engine's output width.
- MULT_WIDTH, 16, signed requant multiplier width.
- SHIFT_WIDTH, 5, right-shift amount width (shift range 0..31).
- OUT_WIDTH, 8, unsigned output width.
- CNT_WIDTH, 16, saturation event counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  IN_WIDTH  signed pre-activation value.
- din_valid  in  1  din qualifier.
- din_ready  out  1  stage can accept din this cycle.
- dout  out  OUT_WIDTH  unsigned quantized activation.
- dout_valid  out  1  dout qualifier.
- dout_ready  in  1  downstream accepts dout.
- mult_config  in  MULT_WIDTH  signed scale multiplier.
- shift_config  in  SHIFT_WIDTH  right shift.
- zp_config  in  OUT_WIDTH  unsigned output zero point.
- relu_config  in  1  1 = clamp negatives to 0 before the zero-point add.
- config_en  in  1  load request for all config registers.
- config_err  out  1  one-cycle pulse when config_en is rejected.
- sat_count  out  CNT_WIDTH  count of delivered outputs that saturated.

Behaviour:
- Reset (async, active-low) values:
  - All config registers 0.
  - All stage valids 0, so dout_valid=0.
  - dout=0, config_err=0, sat_count=0.
  - Reset mid-operation discards in-flight data; no output beat follows reset release until new input.
- Stall control:
  - pipe_en = dout_ready | ~dout_valid.
  - din_ready = pipe_en (combinational).
  - All stages advance together only when pipe_en=1; otherwise every stage holds data and valid.
  - Input transfer on din_valid & din_ready; output transfer on dout_valid & dout_ready.
  - Bubbles propagate as valid=0 and are squeezed out when the output is empty.
- Stage 1: p = din * mult (signed x signed, IN_WIDTH+MULT_WIDTH bits); v1 = din_valid.
- Stage 2 (rounding):
  - shift=0: r = p.
  - Otherwise: r = (p + 2^(shift-1)) >>> shift, arithmetic, computed one bit wider than p so it cannot overflow.
  - This is round half toward +infinity.
- Stage 3:
  - If relu=1 and r<0, r=0.
  - y = r + zp, signed, wide.
  - If y>2^OUT_WIDTH-1, dout=all ones and sat flag=1.
  - Else if y<0, dout=0 and sat flag=1.
  - Else dout=y[OUT_WIDTH-1:0] and sat flag=0.
- Latency: 3 cycles from input transfer to dout_valid when never stalled. Throughput 1/cycle.
- Config:
  - config_en is accepted only when the pipeline is empty: v1, v2, dout_valid and din_valid all 0.
  - On accept: the four config registers load at the clock edge and sat_count clears to 0.
  - If config_en arrives while not empty, it is ignored and config_err=1 for that cycle.
  - Data never sees mixed config.
- sat_count:
  - Increments on each output transfer whose sat flag is 1.
  - Sticks at all ones; never wraps.
  - An accepted config_en has priority over an increment in the same cycle, but cannot coincide with one, since an output transfer implies the pipeline is not empty.

Decomposition:
- Shared package `cnn_quant_pkg`:
  - Width constants IN_WIDTH/OUT_WIDTH shared with conv1x1 stages.
  - Helper function round_shift.
  - Constant UQ_MAX = 2^OUT_WIDTH-1.
- One natural sub-module: `round_shift_sat`, the combinational rounding plus clamp/saturate datapath. Pipeline registers and control stay in the top.

Test Plan:
- Scaling: mult=16384, shift=15, zp=0, relu=1, din=101 -> dout=51 (50.5 rounds up), 3 cycles after acceptance; din=100 -> 50.
- ReLU and zero point: same scale.
  - relu=1, din=-20 -> dout=0, sat_count unchanged.
  - relu=0, zp=128, din=-20 -> dout=118.
  - relu=0, zp=0, din=-20 -> dout=0, sat_count+1.
- Saturation: mult=16384, shift=15, din=1000 -> dout=255, sat_count=1. din=-131072, relu=0, zp=0 -> dout=0, sat_count=2.
- Backpressure: stream din=2,4,6,8,10 (scale 0.5) with dout_ready low for 4 cycles mid-stream.
  - dout stable while held; din_ready=0 while output full.
  - Outputs exactly 1,2,3,4,5 in order, none lost or duplicated.
- Config guard: assert config_en with a beat in stage 2 -> config_err pulse, old scale still applied. Repeat when empty -> accepted, sat_count=0.
- Reset mid-stream: pulse rst_n low with 3 beats in flight -> dout_valid=0 immediately, no stale beat after release, config back to 0 (dout=0 for any din).
